// File: rtl/matmul_sched.sv
// matmul_sched: job-level scheduler sharing one 4x4 matmul engine between two stream requesters.
// Define MATMUL_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module matmul_sched #(
    parameter int unsigned pDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s0_tvalid,
    input  logic [pDATA_WIDTH-1:0] s0_tdata,
    input  logic                   s0_tlast,
    output logic                   s0_tready,
    input  logic                   s1_tvalid,
    input  logic [pDATA_WIDTH-1:0] s1_tdata,
    input  logic                   s1_tlast,
    output logic                   s1_tready,
    output logic                   m0_tvalid,
    output logic [pDATA_WIDTH-1:0] m0_tdata,
    output logic                   m0_tlast,
    input  logic                   m0_tready,
    output logic                   m1_tvalid,
    output logic [pDATA_WIDTH-1:0] m1_tdata,
    output logic                   m1_tlast,
    input  logic                   m1_tready,
    output logic                   eng_ap_start,
    output logic                   eng_ss_tvalid,
    output logic [pDATA_WIDTH-1:0] eng_ss_tdata,
    output logic                   eng_ss_tlast,
    input  logic                   eng_ss_tready,
    input  logic                   eng_sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] eng_sm_tdata,
    output logic                   eng_sm_tready,
    output logic                   busy,
    output logic                   owner,
    output logic [1:0]             err,
    input  logic                   err_clr
);

    typedef enum logic [2:0] {StIdle, StStart, StFeed, StCollect, StDrain} state_e;

    state_e                 r_state, w_state_d;
    logic                   r_owner, w_owner_d;
    logic [5:0]             r_in_cnt, w_in_cnt_d;
    logic [3:0]             r_wr_ptr, w_wr_ptr_d;
    logic [3:0]             r_rd_ptr, w_rd_ptr_d;
    logic                   r_pad, w_pad_d;
    logic [1:0]             r_err, w_err_d, w_err_set;
    logic [pDATA_WIDTH-1:0] r_buf [16];

    logic                   w_s_tvalid;
    logic                   w_s_tlast;
    logic [pDATA_WIDTH-1:0] w_s_tdata;
    logic                   w_m_tready;
    logic                   w_ss_hs;
    logic                   w_m_hs;
    logic                   w_drain_done;
    logic                   w_buf_we;
    logic                   w_grant;

    assign w_s_tvalid   = r_owner ? s1_tvalid : s0_tvalid;
    assign w_s_tlast    = r_owner ? s1_tlast  : s0_tlast;
    assign w_s_tdata    = r_owner ? s1_tdata  : s0_tdata;
    assign w_m_tready   = r_owner ? m1_tready : m0_tready;
    // Once padding starts the engine sees a constant valid zero word.
    assign w_ss_hs      = (r_state == StFeed) & (r_pad | w_s_tvalid) & eng_ss_tready;
    assign w_m_hs       = (r_state == StDrain) & w_m_tready;
    assign w_drain_done = w_m_hs & (r_rd_ptr == 4'd15);

    assign eng_sm_tready = 1'b1;
    assign busy          = (r_state != StIdle);
    assign owner         = r_owner;
    assign err           = r_err;

`ifdef MATMUL_SCHED_FIXED_PRIO_EN
    assign w_grant = ~s0_tvalid;
`else
    logic r_last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_drain_done) begin
            r_last_grant <= r_owner;
        end
    end

    assign w_grant = (s0_tvalid && s1_tvalid) ? ~r_last_grant : ~s0_tvalid;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_owner_d     = r_owner;
        w_in_cnt_d    = r_in_cnt;
        w_wr_ptr_d    = r_wr_ptr;
        w_rd_ptr_d    = r_rd_ptr;
        w_pad_d       = r_pad;
        w_err_set     = 2'b00;
        w_buf_we      = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        m0_tvalid     = 1'b0;
        m0_tdata      = '0;
        m0_tlast      = 1'b0;
        m1_tvalid     = 1'b0;
        m1_tdata      = '0;
        m1_tlast      = 1'b0;
        eng_ap_start  = 1'b0;
        eng_ss_tvalid = 1'b0;
        eng_ss_tdata  = '0;
        eng_ss_tlast  = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (s0_tvalid || s1_tvalid) begin
                    w_owner_d = w_grant;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                eng_ap_start = 1'b1;
                w_in_cnt_d   = '0;
                w_wr_ptr_d   = '0;
                w_rd_ptr_d   = '0;
                w_pad_d      = 1'b0;
                w_state_d    = StFeed;
            end
            StFeed: begin
                eng_ss_tlast = (r_in_cnt == 6'd31);
                if (r_pad) begin
                    eng_ss_tvalid = 1'b1;
                end else begin
                    eng_ss_tvalid = w_s_tvalid;
                    eng_ss_tdata  = w_s_tdata;
                    if (r_owner) s1_tready = eng_ss_tready;
                    else         s0_tready = eng_ss_tready;
                end
                if (w_ss_hs) begin
                    w_in_cnt_d = r_in_cnt + 6'd1;
                    // Early tlast and missing final tlast are both framing errors.
                    if (!r_pad && (w_s_tlast != (r_in_cnt == 6'd31))) begin
                        w_err_set[r_owner] = 1'b1;
                    end
                    if (!r_pad && w_s_tlast && (r_in_cnt != 6'd31)) begin
                        w_pad_d = 1'b1;
                    end
                    if (r_in_cnt == 6'd31) begin
                        w_state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (eng_sm_tvalid) begin
                    w_buf_we   = 1'b1;
                    w_wr_ptr_d = r_wr_ptr + 4'd1;
                    if (r_wr_ptr == 4'd15) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (r_owner) begin
                    m1_tvalid = 1'b1;
                    m1_tdata  = r_buf[r_rd_ptr];
                    m1_tlast  = (r_rd_ptr == 4'd15);
                end else begin
                    m0_tvalid = 1'b1;
                    m0_tdata  = r_buf[r_rd_ptr];
                    m0_tlast  = (r_rd_ptr == 4'd15);
                end
                if (w_m_hs) begin
                    w_rd_ptr_d = r_rd_ptr + 4'd1;
                end
                if (w_drain_done) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // A new error in the same cycle as a clear survives.
        w_err_d = (err_clr ? 2'b00 : r_err) | w_err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_owner  <= 1'b0;
            r_in_cnt <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_pad    <= 1'b0;
            r_err    <= 2'b00;
        end else begin
            r_state  <= w_state_d;
            r_owner  <= w_owner_d;
            r_in_cnt <= w_in_cnt_d;
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_pad    <= w_pad_d;
            r_err    <= w_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_ptr] <= eng_sm_tdata;
        end
    end

endmodule

// File: tb/tb_matmul_sched.sv
// Scoreboard bench for matmul_sched with a behavioural 4x4 matmul engine model.
// Expected grant order follows MATMUL_SCHED_FIXED_PRIO_EN when defined.
module tb_matmul_sched;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
    logic [W-1:0] s0_tdata = '0;
    logic         s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
    logic [W-1:0] s1_tdata = '0;
    logic         m0_tvalid, m0_tlast, m0_tready = 1'b1;
    logic [W-1:0] m0_tdata;
    logic         m1_tvalid, m1_tlast, m1_tready = 1'b1;
    logic [W-1:0] m1_tdata;
    logic         eng_ap_start, eng_ss_tvalid, eng_ss_tlast, eng_ss_tready = 1'b1;
    logic [W-1:0] eng_ss_tdata;
    logic         eng_sm_tvalid = 1'b0, eng_sm_tready;
    logic [W-1:0] eng_sm_tdata = '0;
    logic         busy, owner, err_clr = 1'b0;
    logic [1:0]   err;

    always #5 clk = ~clk;

    matmul_sched #(.pDATA_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m0_tvalid(m0_tvalid), .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tready(m0_tready),
        .m1_tvalid(m1_tvalid), .m1_tdata(m1_tdata), .m1_tlast(m1_tlast), .m1_tready(m1_tready),
        .eng_ap_start(eng_ap_start), .eng_ss_tvalid(eng_ss_tvalid), .eng_ss_tdata(eng_ss_tdata),
        .eng_ss_tlast(eng_ss_tlast), .eng_ss_tready(eng_ss_tready),
        .eng_sm_tvalid(eng_sm_tvalid), .eng_sm_tdata(eng_sm_tdata), .eng_sm_tready(eng_sm_tready),
        .busy(busy), .owner(owner), .err(err), .err_clr(err_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] exp_q0[$];
    logic [W:0] exp_q1[$];
    logic       grant_q[$];
    bit         abort = 1'b0;
    bit         m0_bp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected normal completion", name);
    endtask

    // Ready drivers; change only just after the active edge.
    int cyc = 0;
    logic [3:0] bp_pat = 4'b1001;
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        eng_ss_tready = (cyc % 7) != 3;
        m0_tready     = m0_bp ? bp_pat[cyc % 4] : 1'b1;
        m1_tready     = 1'b1;
    end

    // Engine model: captures 32 words after ap_start, then emits A*B as 16 back-to-back words.
    logic [W-1:0] e_in [32];
    int e_cnt = 0;
    int e_out = 16;

    function automatic logic [W-1:0] e_res(input int idx);
        logic [W-1:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s += e_in[(idx / 4) * 4 + k] * e_in[16 + k * 4 + idx % 4];
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            e_cnt = 0;
            e_out = 16;
            eng_sm_tvalid = 1'b0;
            eng_sm_tdata  = '0;
        end else begin
            if (e_out < 16) begin
                eng_sm_tvalid = 1'b1;
                eng_sm_tdata  = e_res(e_out);
                e_out++;
            end else begin
                eng_sm_tvalid = 1'b0;
            end
            if (eng_ap_start) begin
                e_cnt = 0;
            end else if (eng_ss_tvalid && eng_ss_tready && e_cnt < 32) begin
                chk("eng_tlast", eng_ss_tlast, (e_cnt == 31));
                e_in[e_cnt] = eng_ss_tdata;
                e_cnt++;
                if (e_cnt == 32) e_out = 0;
            end
        end
    end

    // Monitor: grants, non-owner silence, result scoreboard and stall stability.
    bit cur_valid = 1'b0;
    bit cur_owner = 1'b0;
    bit stall0 = 1'b0, stall1 = 1'b0;
    logic [W-1:0] hold0, hold1;

    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst_n) begin
            cur_valid = 1'b0;
            stall0 = 1'b0;
            stall1 = 1'b0;
        end else begin
            if (eng_ap_start) begin
                if (grant_q.size() == 0) begin
                    fail_now("unexpected_start");
                end else begin
                    cur_owner = grant_q.pop_front();
                    cur_valid = 1'b1;
                    chk("grant_owner", owner, cur_owner);
                end
            end
            if (busy && cur_valid) begin
                if (cur_owner) begin
                    chk("nonowner_s0_tready", s0_tready, 0);
                    chk("nonowner_m0_tvalid", m0_tvalid, 0);
                end else begin
                    chk("nonowner_s1_tready", s1_tready, 0);
                    chk("nonowner_m1_tvalid", m1_tvalid, 0);
                end
            end
            if (stall0) begin
                chk("m0_hold_valid", m0_tvalid, 1);
                chk("m0_hold_data", m0_tdata, hold0);
            end
            if (stall1) begin
                chk("m1_hold_valid", m1_tvalid, 1);
                chk("m1_hold_data", m1_tdata, hold1);
            end
            if (m0_tvalid && m0_tready) begin
                if (exp_q0.size() == 0) fail_now("m0_unexpected_word");
                else begin
                    e = exp_q0.pop_front();
                    chk("m0_tdata", m0_tdata, e[W-1:0]);
                    chk("m0_tlast", m0_tlast, e[W]);
                end
            end
            if (m1_tvalid && m1_tready) begin
                if (exp_q1.size() == 0) fail_now("m1_unexpected_word");
                else begin
                    e = exp_q1.pop_front();
                    chk("m1_tdata", m1_tdata, e[W-1:0]);
                    chk("m1_tlast", m1_tlast, e[W]);
                end
            end
            stall0 = m0_tvalid && !m0_tready;
            stall1 = m1_tvalid && !m1_tready;
            hold0  = m0_tdata;
            hold1  = m1_tdata;
        end
    end

    // A = scale*I, B[k] = base+k, so C = scale*B; rows of B never sent are zero-padded.
    task automatic push_exp(input bit ch, input int scale, input int base, input int nrows);
        logic [W:0] e;
        for (int i = 0; i < 16; i++) begin
            e[W-1:0] = (i / 4 < nrows) ? W'(scale * (base + i)) : '0;
            e[W]     = (i == 15);
            if (ch) exp_q1.push_back(e);
            else    exp_q0.push_back(e);
        end
    endtask

    task automatic drive(input bit ch, input logic v, input logic [W-1:0] d, input logic l);
        if (ch) begin s1_tvalid = v; s1_tdata = d; s1_tlast = l; end
        else    begin s0_tvalid = v; s0_tdata = d; s0_tlast = l; end
    endtask

    task automatic send_job(input bit ch, input int scale, input int base, input int nwords,
                            input int tlast_idx);
        logic [W-1:0] word;
        for (int i = 0; i < nwords; i++) begin
            int t;
            bit got;
            word = (i < 16) ? ((i / 4 == i % 4) ? W'(scale) : '0) : W'(base + i - 16);
            drive(ch, 1'b1, word, (i == tlast_idx));
            t = 0;
            got = 1'b0;
            while (!got) begin
                @(negedge clk);
                if (abort) begin
                    drive(ch, 1'b0, '0, 1'b0);
                    return;
                end
                got = ch ? s1_tready : s0_tready;
                t++;
                if (!got && t > 5000) begin
                    fail_now("send_ready_timeout");
                    drive(ch, 1'b0, '0, 1'b0);
                    return;
                end
            end
            @(posedge clk);
            #1;
        end
        drive(ch, 1'b0, '0, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || exp_q0.size() != 0 || exp_q1.size() != 0 || grant_q.size() != 0)
                   && t < 20000);
        if (t >= 20000) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_after_clear", err, 2'b00);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_s0_tready"}, s0_tready, 0);
        chk({tag, "_s1_tready"}, s1_tready, 0);
        chk({tag, "_m0_tvalid"}, {m0_tvalid, m0_tlast, m0_tdata}, 0);
        chk({tag, "_m1_tvalid"}, {m1_tvalid, m1_tlast, m1_tdata}, 0);
        chk({tag, "_eng_ap_start"}, eng_ap_start, 0);
        chk({tag, "_eng_ss"}, {eng_ss_tvalid, eng_ss_tlast, eng_ss_tdata}, 0);
        chk({tag, "_eng_sm_tready"}, eng_sm_tready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_err"}, err, 2'b00);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #10;
        reset_checks("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Tie twice in succession from both requesters.
`ifdef MATMUL_SCHED_FIXED_PRIO_EN
        grant_q.push_back(1'b0); grant_q.push_back(1'b0);
        grant_q.push_back(1'b1); grant_q.push_back(1'b1);
`else
        grant_q.push_back(1'b0); grant_q.push_back(1'b1);
        grant_q.push_back(1'b0); grant_q.push_back(1'b1);
`endif
        push_exp(0, 1, 1, 4);
        push_exp(0, 2, 1, 4);
        push_exp(1, 1, 101, 4);
        push_exp(1, 3, 1, 4);
        fork
            begin send_job(0, 1, 1, 32, 31);   send_job(0, 2, 1, 32, 31); end
            begin send_job(1, 1, 101, 32, 31); send_job(1, 3, 1, 32, 31); end
        join
        wait_idle("tie_jobs_done");
        chk("tie_err", err, 2'b00);

        // Single job A=I, B=1..16 with 1,0,0,1 drain backpressure.
        m0_bp = 1'b1;
        grant_q.push_back(1'b0);
        push_exp(0, 1, 1, 4);
        send_job(0, 1, 1, 32, 31);
        wait_idle("single_job_done");
        chk("single_err", err, 2'b00);
        m0_bp = 1'b0;

        // Early tlast on word 20 from s1: only B row 0 reaches the engine.
        grant_q.push_back(1'b1);
        push_exp(1, 1, 1, 1);
        send_job(1, 1, 1, 20, 19);
        wait_idle("early_tlast_done");
        chk("early_tlast_err", err, 2'b10);
        clear_err();

        // Word 32 without tlast from s0: accepted, error flagged.
        grant_q.push_back(1'b0);
        push_exp(0, 1, 50, 4);
        send_job(0, 1, 50, 32, -1);
        wait_idle("missing_tlast_done");
        chk("missing_tlast_err", err, 2'b01);
        clear_err();

        // Reset in the middle of FEED, then a clean s1 job.
        grant_q.push_back(1'b0);
        fork
            send_job(0, 1, 1, 32, 31);
            begin
                int t = 0;
                while (e_cnt < 10 && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 5000) fail_now("midfeed_wait");
                rst_n = 1'b0;
                abort = 1'b1;
            end
        join
        #1;
        reset_checks("midreset");
        exp_q0.delete();
        exp_q1.delete();
        grant_q.delete();
        abort = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        grant_q.push_back(1'b1);
        push_exp(1, 2, 1, 4);
        send_job(1, 2, 1, 32, 31);
        wait_idle("post_reset_job_done");
        chk("post_reset_err", err, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before 400000ns");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matmul_sched.md
# matmul_sched

Job-level scheduler that shares one 4x4 matmul engine between two AXI-stream requesters (DMA channels 0 and 1). It arbitrates whole jobs and pulses the engine's `ap_start`. It forwards the owner's 32 input words (16 A, then 16 B, row-major) and captures the engine's 16 un-backpressured result words into a local buffer. It then returns those words to the owning requester with full AXI-stream backpressure. It sits between the user-project DMA ports and the matmul engine.

## Interface
- `pDATA_WIDTH`, default 32: stream data width.
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `s0_tvalid`/`s0_tdata`/`s0_tlast` in, 1/`pDATA_WIDTH`/1: requester 0 job input.
- `s0_tready` out, 1: requester 0 input ready.
- `s1_tvalid`/`s1_tdata`/`s1_tlast` in, 1/`pDATA_WIDTH`/1: requester 1 job input.
- `s1_tready` out, 1: requester 1 input ready.
- `m0_tvalid`/`m0_tdata`/`m0_tlast` out, 1/`pDATA_WIDTH`/1: results to requester 0.
- `m0_tready` in, 1: requester 0 result ready.
- `m1_tvalid`/`m1_tdata`/`m1_tlast` out, 1/`pDATA_WIDTH`/1: results to requester 1.
- `m1_tready` in, 1: requester 1 result ready.
- `eng_ap_start` out, 1: one-cycle start pulse to the engine.
- `eng_ss_tvalid`/`eng_ss_tdata`/`eng_ss_tlast` out, 1/`pDATA_WIDTH`/1: engine input stream.
- `eng_ss_tready` in, 1: engine input ready.
- `eng_sm_tvalid`/`eng_sm_tdata` in, 1/`pDATA_WIDTH`: engine result stream (ignores tready).
- `eng_sm_tready` out, 1: driven to constant 1.
- `busy` out, 1: high in any state other than IDLE.
- `owner` out, 1: index of the current or most recent grant.
- `err` out, 2: sticky framing error, one bit per requester.
- `err_clr` in, 1: synchronous clear of `err`.

## Operation
- **States:** IDLE, START, FEED, COLLECT, DRAIN.
- **IDLE:**
  - Requests are `s0_tvalid` and `s1_tvalid`.
  - If any request is present, latch `owner` and go to START.
  - Round-robin: the requester not granted last wins a tie. `last_grant` resets to 1, so requester 0 wins the first tie.
- **START:** `eng_ap_start`=1 for exactly one cycle. Clear `in_cnt`, `wr_ptr` and `rd_ptr`. Go to FEED.
- **FEED:** combinational pass-through of the owner's stream.
  - `eng_ss_tvalid`=`sN_tvalid`, `eng_ss_tdata`=`sN_tdata`, `sN_tready`=`eng_ss_tready`.
  - The non-owner's `tready` is 0.
  - `in_cnt` (6-bit) increments on each engine handshake. `eng_ss_tlast`=1 when `in_cnt`==31.
  - After the handshake at `in_cnt`==31, go to COLLECT.
- **Framing errors:**
  - If `sN_tlast` arrives with `in_cnt`<31: set `err[N]`, drop `sN_tready` for the rest of the job, and pad the remaining words with `eng_ss_tvalid`=1, `eng_ss_tdata`=0.
  - If the word at `in_cnt`==31 has no `tlast`: set `err[N]` and accept the word anyway.
- **COLLECT:** each `eng_sm_tvalid` cycle writes `eng_sm_tdata` to `buf[wr_ptr]` and increments `wr_ptr`. After 16 writes, go to DRAIN.
- **DRAIN:**
  - `mN_tvalid`=1, `mN_tdata`=`buf[rd_ptr]`, `mN_tlast`=(`rd_ptr`==15).
  - `rd_ptr` increments on handshake.
  - After the last handshake: `last_grant`<=`owner`, go to IDLE.
- **Error flags:** `err_clr` clears `err`. A set in the same cycle as `err_clr` wins.
- **Counters:** `in_cnt` never wraps inside a job. `wr_ptr` and `rd_ptr` are 4-bit and wrap to 0 after word 15, which coincides with the state exit.

## Timing
- **Reset values:** all `sN_tready`, `mN_tvalid`, `mN_tlast`, `eng_ap_start`, `eng_ss_tvalid`, `eng_ss_tlast`, `busy`, `owner` and `err` are 0. All `mN_tdata` and `eng_ss_tdata` are 0. `eng_sm_tready` is 1. State is IDLE.
- **Reset mid-job:** the scheduler returns to reset values. The engine shares `rst_n`, so no partial job survives.
- **Grant latency:** `tvalid` seen in IDLE at cycle t gives START at t+1 (`eng_ap_start` high) and FEED from t+2.
- **FEED path:** zero added latency; no registered stage in the data path.
- **Drain start:** the first `mN_tvalid` appears the cycle after the 16th COLLECT write.
- **Buffer:** holds all 16 results, so engine bursts are never lost.
- **DRAIN:** honours `mN_tready` stalls indefinitely; data is stable while `tvalid`=1 and `tready`=0.
- **Back-to-back jobs:** a request present during DRAIN is granted in the first IDLE cycle. Minimum IDLE dwell is 1 cycle.

## Configuration
- `MATMUL_SCHED_FIXED_PRIO_EN` defined: requester 0 always wins a tie, and `last_grant` is ignored.
- `MATMUL_SCHED_FIXED_PRIO_EN` undefined: round-robin arbitration as specified under Operation.

## Test plan
- **Single job:** s0 sends A=identity and B=1..16 with `tlast` on word 32, `m0_tready`=1. Expect one `eng_ap_start` pulse, `m0` outputs 1..16 with `tlast` on the 16th word, and `err`=0.
- **Tie, round-robin:** s0 and s1 both assert `tvalid` in IDLE, twice in succession. Expect grants s0, s1, s0, s1; each result goes only to its own `mN`; the non-owner's `tready` stays 0 throughout.
- **Early tlast:** s1 asserts `tlast` on word 20. Expect `err`=2'b10, words 21..32 sent to the engine as 0, and 16 results still drained on `m1`.
- **Drain backpressure:** `m0_tready` toggles 1,0,0,1 during DRAIN. Expect `m0_tdata` to hold during stalls and no word lost or repeated.
- **Fixed priority:** with `MATMUL_SCHED_FIXED_PRIO_EN` defined, repeated ties give s0 every time.
- **Reset mid-FEED:** assert `rst_n` low at `in_cnt`=10. Expect all outputs at reset values; a new s1 job then completes correctly.
